// File: rtl/timer_array_if.sv
// -----------------------------------------------------------------------------
// timer_array_if
//
// Purpose: bundles the configuration inputs and status outputs of timer_array
// so the block and its driver share one port list. clk and rst stay as plain
// ports on the modules themselves.
//
// Signals (parameterised by NUM_CH, CNT_W, PSC_W):
//   prescaler       shared tick divider, tick every prescaler+1 clk cycles
//   autoreload      flattened per-channel reload/compare, ch i at [i*CNT_W +: CNT_W]
//   ch_enable       per-channel run enable
//   ch_mode         1 = periodic auto-reload, 0 = one-shot
//   ch_dir          0 = count up, 1 = count down
//   ch_clear        per-channel synchronous counter clear (level)
//   irq_mask        per-channel interrupt mask (1 = contributes)
//   irq_ack         per-channel write-1-to-clear of timer_status
//   timer_count     flattened live counter values
//   timer_event     one-cycle terminal-event pulse per channel
//   timer_status    sticky per-channel event flag
//   timer_interrupt OR over channels of (timer_status & irq_mask)
//
// Modports:
//   master  drives configuration, observes status (software / testbench side)
//   slave   the timer block itself
// -----------------------------------------------------------------------------
interface timer_array_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int PSC_W  = 8
);
    logic [PSC_W-1:0]        prescaler;
    logic [NUM_CH*CNT_W-1:0] autoreload;
    logic [NUM_CH-1:0]       ch_enable;
    logic [NUM_CH-1:0]       ch_mode;
    logic [NUM_CH-1:0]       ch_dir;
    logic [NUM_CH-1:0]       ch_clear;
    logic [NUM_CH-1:0]       irq_mask;
    logic [NUM_CH-1:0]       irq_ack;

    logic [NUM_CH*CNT_W-1:0] timer_count;
    logic [NUM_CH-1:0]       timer_event;
    logic [NUM_CH-1:0]       timer_status;
    logic                    timer_interrupt;

    modport master (
        output prescaler,
        output autoreload,
        output ch_enable,
        output ch_mode,
        output ch_dir,
        output ch_clear,
        output irq_mask,
        output irq_ack,
        input  timer_count,
        input  timer_event,
        input  timer_status,
        input  timer_interrupt
    );

    modport slave (
        input  prescaler,
        input  autoreload,
        input  ch_enable,
        input  ch_mode,
        input  ch_dir,
        input  ch_clear,
        input  irq_mask,
        input  irq_ack,
        output timer_count,
        output timer_event,
        output timer_status,
        output timer_interrupt
    );
endinterface

// File: rtl/timer_array.sv
// -----------------------------------------------------------------------------
// timer_array
//
// Purpose: NUM_CH independent general-purpose timers sharing one prescaler.
// Each channel counts up or down on the shared tick, in periodic (auto-reload)
// or one-shot mode, raises a one-cycle event at its terminal count, and keeps
// a sticky status flag that can be masked into a single interrupt line.
//
// Ports:
//   clk   single clock, all state changes on its rising edge
//   rst   asynchronous active-low reset; clears every register at once
//   bus   timer_array_if.slave -- configuration in, count/event/status out
//
// Notes:
//   - The prescaler only runs while at least one channel is enabled, so the
//     very first enabled cycle after an all-idle period can already tick when
//     prescaler == 0.
//   - A channel in IDLE that sees enable together with a tick counts on that
//     tick (it moves to RUN on the same edge), so no tick is lost on start.
//   - Count and event are registered on the same edge: the event pulse lines
//     up with the count update that caused it.
// -----------------------------------------------------------------------------
module timer_array #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int PSC_W  = 8
) (
    input  logic          clk,
    input  logic          rst,
    timer_array_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ch_state_t;

    // -------------------------------------------------------------------------
    // Shared prescaler
    // -------------------------------------------------------------------------
    logic [PSC_W-1:0] psc_q;
    logic [PSC_W-1:0] psc_d;
    logic             any_en;
    logic             tick;

    assign any_en = |bus.ch_enable;

    // Tick fires in the cycle the counter equals the divider value.
    assign tick = any_en && (psc_q == bus.prescaler);

    // The >= wrap keeps the counter from running off the top if software
    // lowers the divider below the current counter value.
    always_comb begin
        psc_d = '0;
        if (any_en && (psc_q < bus.prescaler)) begin
            psc_d = psc_q + PSC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end

    // -------------------------------------------------------------------------
    // Per-channel timers
    // -------------------------------------------------------------------------
    logic [NUM_CH-1:0] event_vec;
    logic [NUM_CH-1:0] status_vec;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            ch_state_t        st_q;
            ch_state_t        st_d;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             evt_q;
            logic             evt_d;
            logic             stat_q;
            logic             stat_d;
            logic [CNT_W-1:0] arr;

            assign arr = bus.autoreload[gi*CNT_W +: CNT_W];

            always_comb begin
                st_d  = st_q;
                cnt_d = cnt_q;
                evt_d = 1'b0;

                if (bus.ch_clear[gi]) begin
                    // Clear beats any coincident tick and re-arms a finished
                    // one-shot; no event is ever produced in a clear cycle.
                    cnt_d = bus.ch_dir[gi] ? arr : '0;
                    st_d  = bus.ch_enable[gi] ? ST_RUN : ST_IDLE;
                end else if (!bus.ch_enable[gi]) begin
                    // Disabling parks the channel with its count held.
                    st_d = ST_IDLE;
                end else begin
                    case (st_q)
                        ST_IDLE, ST_RUN: begin
                            st_d = ST_RUN;
                            if (tick) begin
                                if (!bus.ch_dir[gi]) begin
                                    // Up: >= so a count stranded above a
                                    // lowered reload value wraps next tick.
                                    if (cnt_q >= arr) begin
                                        evt_d = 1'b1;
                                        if (bus.ch_mode[gi]) begin
                                            cnt_d = '0;
                                        end else begin
                                            st_d = ST_DONE;
                                        end
                                    end else begin
                                        cnt_d = cnt_q + CNT_W'(1);
                                    end
                                end else begin
                                    if (cnt_q == '0) begin
                                        evt_d = 1'b1;
                                        if (bus.ch_mode[gi]) begin
                                            cnt_d = arr;
                                        end else begin
                                            st_d = ST_DONE;
                                        end
                                    end else begin
                                        cnt_d = cnt_q - CNT_W'(1);
                                    end
                                end
                            end
                        end
                        default: begin
                            // ST_DONE: frozen until cleared or disabled.
                            st_d = st_q;
                        end
                    endcase
                end

                // A new event outranks a simultaneous acknowledge.
                stat_d = evt_d | (stat_q & ~bus.irq_ack[gi]);
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    st_q   <= ST_IDLE;
                    cnt_q  <= '0;
                    evt_q  <= 1'b0;
                    stat_q <= 1'b0;
                end else begin
                    st_q   <= st_d;
                    cnt_q  <= cnt_d;
                    evt_q  <= evt_d;
                    stat_q <= stat_d;
                end
            end

            assign bus.timer_count[gi*CNT_W +: CNT_W] = cnt_q;
            assign event_vec[gi]  = evt_q;
            assign status_vec[gi] = stat_q;
        end
    endgenerate

    assign bus.timer_event     = event_vec;
    assign bus.timer_status    = status_vec;
    assign bus.timer_interrupt = |(status_vec & bus.irq_mask);

endmodule
